alu_addsub_pipe: RTL and testbench

//  Parametrised, pipelined add/subtract/compare unit for the ALU. It replaces the

---
 rtl/alu_addsub_pipe.sv | 178 +++++++++++++++++
 tb/tb_alu_addsub_pipe.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_addsub_pipe.sv
// Pipelined add/sub/compare unit: carry chain cut into CHUNK-bit slices, one slice per stage, STAGES-cycle latency.
// The whole pipe advances when the output register is empty or being drained; otherwise every stage holds.
module alu_addsub_pipe #(
  parameter int         WIDTH   = 32,
  parameter int         CHUNK   = 8,
  parameter logic [4:0] OP_ADD  = 5'd6,
  parameter logic [4:0] OP_SUB  = 5'd7,
  parameter logic [4:0] OP_SLT  = 5'd8,
  parameter logic [4:0] OP_SLTU = 5'd9
) (
  input  logic             soc_clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ALU_dat1,
  input  logic [WIDTH-1:0] ALU_dat2,
  input  logic [4:0]       Instruction_to_ALU,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] AddSub_out,
  output logic             flag_overflow,
  output logic             flag_carry,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             op_illegal
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;
  localparam int NREG   = (STAGES > 1) ? STAGES - 1 : 1;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic [4:0]       op;
  } stage_t;

  stage_t         slc_in  [STAGES];
  stage_t         slc_out [STAGES];
  logic [CHUNK:0] slc_sum [STAGES];
  logic           inv_b;

  stage_t            stg_d [NREG];
  stage_t            stg_q [NREG];
  logic [NREG-1:0]   stg_vld_d, stg_vld_q;

  logic              out_vld_d, out_vld_q;
  logic [WIDTH-1:0]  res_d, res_q;
  logic              ovf_d, ovf_q;
  logic              cy_d, cy_q;
  logic              zero_d, zero_q;
  logic              neg_d, neg_q;
  logic              ill_d, ill_q;

  logic              adv;
  logic              fin_vld;
  logic [WIDTH-1:0]  fin_res;
  logic              fin_ovf, fin_cy, fin_ill;

  assign adv      = ~out_vld_q | out_ready;
  assign in_ready = adv;

  // Slice 0 is resolved in the accept cycle so that the last slice lands in the output register.
  always_comb begin
    inv_b = (Instruction_to_ALU == OP_SUB) | (Instruction_to_ALU == OP_SLT) |
            (Instruction_to_ALU == OP_SLTU);
    slc_in[0].a  = ALU_dat1;
    slc_in[0].b  = inv_b ? ~ALU_dat2 : ALU_dat2;
    slc_in[0].s  = '0;
    slc_in[0].c  = inv_b;
    slc_in[0].op = Instruction_to_ALU;
    for (int k = 1; k < STAGES; k++) begin
      slc_in[k] = stg_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      slc_sum[k] = {1'b0, slc_in[k].a[k*CHUNK +: CHUNK]} +
                   {1'b0, slc_in[k].b[k*CHUNK +: CHUNK]} +
                   {{CHUNK{1'b0}}, slc_in[k].c};
      slc_out[k] = slc_in[k];
      slc_out[k].s[k*CHUNK +: CHUNK] = slc_sum[k][CHUNK-1:0];
      slc_out[k].c = slc_sum[k][CHUNK];
    end
  end

  always_comb begin
    fin_vld = (STAGES == 1) ? in_valid : stg_vld_q[NREG-1];
    fin_res = slc_out[LAST].s;
    fin_cy  = slc_out[LAST].c;
    fin_ill = 1'b0;
    fin_ovf = (slc_out[LAST].a[WIDTH-1] == slc_out[LAST].b[WIDTH-1]) &
              (slc_out[LAST].s[WIDTH-1] != slc_out[LAST].a[WIDTH-1]);
    case (slc_out[LAST].op)
      OP_ADD, OP_SUB: fin_res = slc_out[LAST].s;
      OP_SLT:         fin_res = {{(WIDTH-1){1'b0}}, slc_out[LAST].s[WIDTH-1] ^ fin_ovf};
      OP_SLTU:        fin_res = {{(WIDTH-1){1'b0}}, ~slc_out[LAST].c};
      default: begin
        fin_res = '0;
        fin_ovf = 1'b0;
        fin_cy  = 1'b0;
        fin_ill = 1'b1;
      end
    endcase
  end

  always_comb begin
    stg_d     = stg_q;
    stg_vld_d = stg_vld_q;
    out_vld_d = out_vld_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    cy_d      = cy_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    ill_d     = ill_q;
    if (flush) begin
      stg_vld_d = '0;
      out_vld_d = 1'b0;
    end else if (adv) begin
      stg_vld_d[0] = in_valid;
      if (in_valid) begin
        stg_d[0] = slc_out[0];
      end
      for (int k = 1; k < STAGES - 1; k++) begin
        stg_vld_d[k] = stg_vld_q[k-1];
        if (stg_vld_q[k-1]) begin
          stg_d[k] = slc_out[k];
        end
      end
      out_vld_d = fin_vld;
      if (fin_vld) begin
        res_d  = fin_res;
        ovf_d  = fin_ovf;
        cy_d   = fin_cy;
        zero_d = (fin_res == '0);
        neg_d  = fin_res[WIDTH-1];
        ill_d  = fin_ill;
      end
    end
  end

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NREG; k++) begin
        stg_q[k] <= '0;
      end
      stg_vld_q <= '0;
      out_vld_q <= 1'b0;
      res_q     <= '0;
      ovf_q     <= 1'b0;
      cy_q      <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      stg_q     <= stg_d;
      stg_vld_q <= stg_vld_d;
      out_vld_q <= out_vld_d;
      res_q     <= res_d;
      ovf_q     <= ovf_d;
      cy_q      <= cy_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
      ill_q     <= ill_d;
    end
  end

  assign out_valid     = out_vld_q;
  assign AddSub_out    = res_q;
  assign flag_overflow = ovf_q;
  assign flag_carry    = cy_q;
  assign flag_zero     = zero_q;
  assign flag_neg      = neg_q;
  assign op_illegal    = ill_q;

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Bench for alu_addsub_pipe: three widths (16/4, 32/8, 64/16) driven in lockstep, each with its own scoreboard queue.
module tb_alu_addsub_pipe;

  localparam logic [4:0] OP_ADD = 5'd6, OP_SUB = 5'd7, OP_SLT = 5'd8, OP_SLTU = 5'd9, OP_ILL = 5'd3;

  typedef struct packed {
    logic [63:0] res;
    logic ovf, cy, zero, neg, ill;
  } exp_t;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] a, b, r;
    logic ovf, cy, zero, neg, ill;
  } vec_t;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0]  opc = 5'd0;
  logic [15:0] a16 = '0, b16 = '0, r16;
  logic [31:0] a32 = '0, b32 = '0, r32;
  logic [63:0] a64 = '0, b64 = '0, r64;
  logic [2:0]  rdy, ov, f_ovf, f_cy, f_z, f_n, f_ill;
  exp_t        act [3];
  exp_t        sbq [3][$];
  vec_t        tbl [12];
  int          tests_run = 0, tests_failed = 0;
  int          run_len = 0, last_run = 0;

  always #5 soc_clk = ~soc_clk;

  alu_addsub_pipe #(.WIDTH(16), .CHUNK(4)) u16 (
    .soc_clk(soc_clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[0]),
    .ALU_dat1(a16), .ALU_dat2(b16), .Instruction_to_ALU(opc), .out_valid(ov[0]), .out_ready(out_ready),
    .AddSub_out(r16), .flag_overflow(f_ovf[0]), .flag_carry(f_cy[0]), .flag_zero(f_z[0]),
    .flag_neg(f_n[0]), .op_illegal(f_ill[0]));
  alu_addsub_pipe #(.WIDTH(32), .CHUNK(8)) u32 (
    .soc_clk(soc_clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[1]),
    .ALU_dat1(a32), .ALU_dat2(b32), .Instruction_to_ALU(opc), .out_valid(ov[1]), .out_ready(out_ready),
    .AddSub_out(r32), .flag_overflow(f_ovf[1]), .flag_carry(f_cy[1]), .flag_zero(f_z[1]),
    .flag_neg(f_n[1]), .op_illegal(f_ill[1]));
  alu_addsub_pipe #(.WIDTH(64), .CHUNK(16)) u64 (
    .soc_clk(soc_clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy[2]),
    .ALU_dat1(a64), .ALU_dat2(b64), .Instruction_to_ALU(opc), .out_valid(ov[2]), .out_ready(out_ready),
    .AddSub_out(r64), .flag_overflow(f_ovf[2]), .flag_carry(f_cy[2]), .flag_zero(f_z[2]),
    .flag_neg(f_n[2]), .op_illegal(f_ill[2]));

  assign act[0] = {{48'b0, r16}, f_ovf[0], f_cy[0], f_z[0], f_n[0], f_ill[0]};
  assign act[1] = {{32'b0, r32}, f_ovf[1], f_cy[1], f_z[1], f_n[1], f_ill[1]};
  assign act[2] = {r64, f_ovf[2], f_cy[2], f_z[2], f_n[2], f_ill[2]};

  function automatic int wid(int i);
    return (i == 0) ? 16 : (i == 1) ? 32 : 64;
  endfunction

  // Scales a 32-bit corner value (bits 30:4 all equal) to width w, keeping sign bit and low nibble.
  function automatic logic [63:0] adapt(int w, logic [31:0] v);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = (i == w - 1) ? v[31] : (i >= 4) ? v[30] : v[i];
    return r;
  endfunction

  function automatic exp_t from_tbl(int w, int i);
    exp_t e;
    e = {adapt(w, tbl[i].r), tbl[i].ovf, tbl[i].cy, tbl[i].zero, tbl[i].neg, tbl[i].ill};
    return e;
  endfunction

  function automatic exp_t model(int w, logic [63:0] a_in, logic [63:0] b_in, logic [4:0] op);
    exp_t e;
    logic [63:0] m, a, b, d;
    logic [64:0] sum;
    logic sa, sb, lts, ltu;
    m   = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    a   = a_in & m;
    b   = b_in & m;
    e   = '0;
    sa  = a[w-1];
    sb  = b[w-1];
    d   = (a - b) & m;
    ltu = (a < b);
    lts = (sa != sb) ? sa : ltu;
    case (op)
      OP_ADD: begin
        sum   = {1'b0, a} + {1'b0, b};
        e.res = sum[63:0] & m;
        e.cy  = sum[w];
        e.ovf = (sa == sb) && (e.res[w-1] != sa);
      end
      OP_SUB, OP_SLT, OP_SLTU: begin
        e.cy  = ~ltu;
        e.ovf = (sa != sb) && (d[w-1] != sa);
        e.res = (op == OP_SUB) ? d : (op == OP_SLT) ? {63'b0, lts} : {63'b0, ltu};
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.res == 64'd0);
    e.neg  = e.res[w-1];
    return e;
  endfunction

  task automatic check_exp(string nm, int w, exp_t got, exp_t want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s w=%0d: got res=%h ovf=%b cy=%b z=%b n=%b ill=%b, want res=%h ovf=%b cy=%b z=%b n=%b ill=%b",
               nm, w, got.res, got.ovf, got.cy, got.zero, got.neg, got.ill,
               want.res, want.ovf, want.cy, want.zero, want.neg, want.ill);
    end
  endtask

  task automatic check1(string nm, logic [63:0] got, logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  // Output monitor: compares every valid output against the scoreboard head, pops on handshake.
  always @(negedge soc_clk) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) begin
          if (sbq[i].size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_out w=%0d: got res=%h, want no output", wid(i), act[i].res);
          end else begin
            check_exp("result", wid(i), act[i], sbq[i][0]);
            if (out_ready) void'(sbq[i].pop_front());
          end
        end
      end
      if (ov[1] && out_ready) run_len++;
      else if (!ov[1]) begin
        if (run_len > 0) last_run = run_len;
        run_len = 0;
      end
    end
  end

  // Caller is at posedge+1; holds in_valid until the op is accepted.
  task automatic issue_go(input exp_t e0, input exp_t e1, input exp_t e2);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge soc_clk);
      acc = rdy[1];
      if (acc) begin
        sbq[0].push_back(e0);
        sbq[1].push_back(e1);
        sbq[2].push_back(e2);
      end
      @(posedge soc_clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout: in_ready 0 for %0d cycles, want 1", n);
    end
  endtask

  task automatic issue_vec(input int i);
    opc = tbl[i].op;
    a16 = 16'(adapt(16, tbl[i].a)); b16 = 16'(adapt(16, tbl[i].b));
    a32 = tbl[i].a;                 b32 = tbl[i].b;
    a64 = adapt(64, tbl[i].a);      b64 = adapt(64, tbl[i].b);
    issue_go(from_tbl(16, i), from_tbl(32, i), from_tbl(64, i));
  endtask

  task automatic issue_rand();
    logic [63:0] ra, rb;
    logic [4:0]  op;
    ra = {$urandom, $urandom};
    rb = {$urandom, $urandom};
    op = OP_ADD + 5'($urandom_range(0, 3));
    opc = op;
    a16 = ra[15:0]; b16 = rb[15:0];
    a32 = ra[31:0]; b32 = rb[31:0];
    a64 = ra;       b64 = rb;
    issue_go(model(16, ra, rb, op), model(32, ra, rb, op), model(64, ra, rb, op));
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 60) begin
      @(posedge soc_clk);
      #1;
      n++;
    end
    repeat (2) begin @(posedge soc_clk); #1; end
    for (int i = 0; i < 3; i++) check1($sformatf("%s_pending_w%0d", nm, wid(i)), 64'(sbq[i].size()), 64'd0);
  endtask

  task automatic clear_sb();
    for (int i = 0; i < 3; i++) sbq[i].delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    tbl[0]  = '{OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[1]  = '{OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{OP_ILL,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{OP_ADD,  32'h00000005, 32'h00000000, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{OP_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{OP_SUB,  32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{OP_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{OP_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{OP_SLTU, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{OP_SLT,  32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{OP_SLTU, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{OP_SLT,  32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    #1 reset = 1'b1;
    repeat (3) @(posedge soc_clk);
    #1 reset = 1'b0;
    @(negedge soc_clk);
    for (int i = 0; i < 3; i++) begin
      check_exp("reset_outputs", wid(i), act[i], '0);
      check1($sformatf("reset_out_valid_w%0d", wid(i)), 64'(ov[i]), 64'd0);
      check1($sformatf("reset_in_ready_w%0d", wid(i)), 64'(rdy[i]), 64'd1);
    end
    @(posedge soc_clk);
    #1;

    // Single op: count edges from the accept edge to out_valid.
    issue_vec(0);
    lat = 1;
    while (!ov[1] && lat < 20) begin
      @(posedge soc_clk);
      #1;
      lat++;
    end
    check1("latency_cycles", 64'(lat), 64'd4);
    check1("latency_all_widths_valid", 64'(ov), 64'h7);
    drain("latency");

    for (int i = 0; i < 12; i++) issue_vec(i);
    drain("table");
    check1("table_consecutive_outputs", 64'(last_run), 64'd12);

    for (int i = 0; i < 8; i++) issue_rand();
    drain("stream8");
    check1("stream8_consecutive_outputs", 64'(last_run), 64'd8);

    fork
      for (int i = 0; i < 8; i++) issue_rand();
      begin
        repeat (6) @(posedge soc_clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge soc_clk);
          check1("stall_in_ready", 64'(rdy), 64'h0);
          check1("stall_out_valid", 64'(ov), 64'h7);
          @(posedge soc_clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("stall");

    for (int i = 0; i < 3; i++) issue_rand();
    flush = 1'b1;
    in_valid = 1'b1;
    opc = OP_ADD;
    clear_sb();
    @(posedge soc_clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge soc_clk);
    check1("flush_out_valid", 64'(ov), 64'h0);
    repeat (10) begin @(posedge soc_clk); #1; end
    drain("flush");

    for (int i = 0; i < 5; i++) issue_rand();
    reset = 1'b1;
    in_valid = 1'b1;
    clear_sb();
    #1;
    check1("async_reset_out_valid", 64'(ov), 64'h0);
    @(posedge soc_clk);
    #1;
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge soc_clk);
    check1("post_reset_in_ready", 64'(rdy), 64'h7);
    repeat (10) begin @(posedge soc_clk); #1; end
    drain("reset");

    for (int i = 0; i < 4; i++) issue_vec(i + 4);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
